mmio_console_ctrl: RTL

- Memory-mapped console output controller on the single-cycle core's data bus.
- Decodes CPU stores to a 16-byte register window and buffers character bytes in a FIFO.
- Drains the FIFO to a downstream byte sink (UART TX) over a valid/ready handshake.
- Status and control are readable by firmware in the same cycle, so the no-stall core's print loop can poll `full` and back off.

---
 rtl/mmio_console_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/mmio_console_ctrl.sv
// Memory-mapped console output: CPU stores to a 16-byte window feed a byte FIFO
// that drains to a valid/ready byte sink; status/control are readable in-cycle.
module mmio_console_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          DEPTH     = 16,
  parameter int          AW        = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_re,
  input  logic [3:0]  bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_hit,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_off_e;

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    ovf_q, ovf_d;
  logic          enable_q, enable_d;

  logic     hit, wr_en, do_push, do_ctrl, push_ok, pop, full, empty;
  reg_off_e off;
  logic     unused_bits;

  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:8]};

  assign hit     = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign off     = reg_off_e'(bus_addr[3:2]);
  assign bus_hit = hit && (bus_re || (|bus_we));
  assign wr_en   = hit && bus_we[0];
  assign do_push = wr_en && (off == REG_TXDATA);
  assign do_ctrl = wr_en && (off == REG_CTRL);

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign tx_valid = enable_q && !empty;
  assign tx_data  = tx_valid ? mem[rd_ptr_q] : 8'h00;
  assign pop      = tx_valid && tx_ready;
  // Full is judged on pre-cycle state, so a same-cycle pop never rescues a push.
  assign push_ok  = do_push && !full;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    enable_d = enable_q;

    if (do_push && full && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (do_ctrl) begin
      enable_d = bus_wdata[0];
      if (bus_wdata[1]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        ovf_d    = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
      enable_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      enable_q <= enable_d;
    end
  end

  // NOTE: FIFO storage has no reset; empty/valid come from the reset pointers, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= bus_wdata[7:0];
  end

  always_comb begin
    bus_rdata = 32'h0;
    if (bus_re && hit) begin
      case (off)
        REG_STATUS: bus_rdata = {8'h00, ovf_q, 8'(count_q), 5'b0, enable_q, full, empty};
        REG_CTRL:   bus_rdata = {31'b0, enable_q};
        default:    bus_rdata = 32'h0;
      endcase
    end
  end

endmodule
